wshb_mem_slave: RTL and testbench
=================================

# wshb_mem_slave

Wishbone B4 responder (slave) with on-chip word memory, sitting on the 32-bit system Wishbone bus in the sys_clk domain. It answers the initiator side that the video and SDRAM paths use: classic single cycles and linear incrementing bursts, with byte selects, programmable first-beat wait states and error response for out-of-range addresses. It serves as a stand-in target for the video reader before the SDRAM controller is attached, and as a bench target for any Wishbone master.

## Interface
- DEPTH, 1024: memory size in 32-bit words; power of two, at least 4.
- WAIT, 0: wait cycles inserted before the first ack of every access, 0..15.
- sys_clk  in  1  system clock, 100 MHz; all logic is on its rising edge.
- sys_rst_n  in  1  reset; asynchronous assert, active-low.
- cyc  in  1  bus cycle valid.
- stb  in  1  strobe, transfer request.
- we  in  1  1 = write, 0 = read.
- adr  in  32  byte address; bits [1:0] ignored.
- dat_ms  in  32  write data.
- sel  in  4  byte enables; sel[i] enables dat_ms[8i+7:8i].
- cti  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; others are treated as 000.
- bte  in  2  burst type; only 00 (linear) bursts; other values are treated as classic.
- dat_sm  out  32  read data, valid while ack is 1.
- ack  out  1  normal termination.
- err  out  1  error termination.
- rty  out  1  tied to 0.

## Operation
- Word index = adr[log2(DEPTH)+1:2]. Access is in range when adr < DEPTH*4; otherwise it is out of range.
- States: IDLE, WAIT, ACK, BURST, ERR.
- IDLE: ack=err=0. When cyc&stb is sampled:
  - out of range -> ERR;
  - else WAIT>0 -> WAIT, with counter loaded to WAIT-1;
  - else classic -> ACK, or burst (cti=010, bte=00) -> BURST.
- WAIT: counter decrements each cycle. At 0, go to ACK or BURST using the cti/bte/adr sampled at that edge.
- ACK: ack=1 for exactly one cycle, then return to IDLE. A back-to-back classic request is therefore sampled one cycle after the ack cycle.
- BURST: ack=1 each cycle. Each edge with ack&stb advances the internal word pointer by 1, modulo DEPTH.
  - Leave to IDLE when cti=111 is sampled with ack, when stb=0 is sampled, or when the next pointer would cross DEPTH*4. In the last case the next beat is not acked, and the master must restart, which IDLE turns into ERR.
  - A master that drops stb mid-burst restarts with the full WAIT latency.
- ERR: err=1 for one cycle, dat_sm=0, no write, then return to IDLE.
- cyc=0 sampled in any state -> IDLE at that edge. No write occurs on that edge.
- Write: occurs on an edge where ack=1, stb=1, cyc=1 and we=1. Only the bytes enabled by sel are updated at the current word.
- Read: dat_sm holds mem[word] for the acked address. In BURST, the data for pointer+1 is prefetched so that back-to-back acks carry successive words.
- A read of a word written in the previous beat returns the new data (write-first).

## Timing
- Reset (sys_rst_n=0): ack=0, err=0, rty=0, dat_sm=0, state IDLE, all asynchronous. Memory contents are not reset.
- Classic latency: request sampled at edge n -> ack high during cycle n+1+WAIT, for one cycle.
- Burst: first ack as for classic, then one ack per cycle. A burst of N beats occupies N consecutive ack cycles when stb stays high.
- Err follows the same latency as the first ack, with WAIT ignored: err is high during cycle n+1.
- ack and err are never high in the same cycle. Both are registered and have no combinational path from inputs.
- Reset deasserted mid-transfer: the slave is in IDLE and any pending request is re-sampled as new.

## Test plan
- Classic write: WAIT=0, adr=0x10, sel=1111, 0xDEADBEEF -> ack high one cycle at n+1. Then a classic read of 0x10 returns 0xDEADBEEF with ack.
- Byte enables: write 0x00000000 to 0x20, then write 0xAABBCCDD with sel=0101 -> a read of 0x20 returns 0x00BB00DD.
- Burst read: preload words 0..3 with 0x0,0x1,0x2,0x3. Issue cti 010,010,010,111 from adr 0 -> ack on 4 consecutive cycles carrying 0x0..0x3, then ack=0.
- Out of range: DEPTH=1024, read adr 0x1000 -> err high one cycle at n+1, ack stays 0, memory unchanged.
- Wait states: WAIT=2 classic read -> ack at n+3. A burst with WAIT=2 has only its first beat delayed.
- Aborts:
  - cyc dropped after beat 2 of a 4-beat burst write -> beats 3-4 are not written and ack=0 next cycle.
  - sys_rst_n pulsed low mid-burst -> ack=0 immediately, and the next request takes full latency.

Source files
------------

// File: rtl/wshb_mem_slave.sv
// -----------------------------------------------------------------------------
// wshb_mem_slave
// Wishbone B4 responder backed by an on-chip word memory (sys_clk domain).
// Serves classic single cycles and linear incrementing bursts with byte
// selects and a programmable first-beat wait count. Out-of-range addresses
// get an error termination instead of a memory access.
//
// Parameters
//   DEPTH  memory size in 32-bit words (power of two, >= 4)
//   WAIT   wait cycles before the first ack of every access (0..15)
//
// Ports
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   cyc, stb   in   bus cycle / transfer strobe
//   we         in   1 = write, 0 = read
//   adr        in   byte address, [1:0] ignored
//   dat_ms     in   write data
//   sel        in   byte enables
//   cti, bte   in   cycle type / burst type
//   dat_sm     out  read data, valid with ack
//   ack        out  normal termination (registered)
//   err        out  error termination (registered)
//   rty        out  constant 0
// -----------------------------------------------------------------------------
module wshb_mem_slave #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WAIT  = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat_ms,
  input  logic [3:0]  sel,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err,
  output logic        rty
);

  localparam int unsigned   AW        = $clog2(DEPTH);
  localparam logic [3:0]    WAIT_LD   = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_BURST,
    S_ERR
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] ptr_q;
  logic          ack_q;
  logic          err_q;
  logic [31:0]   dat_q;

  logic [31:0]   mem [DEPTH];

  logic          in_range;
  logic          burst_req;
  logic          last_cti;
  logic          mem_we;
  logic [AW-1:0] adr_word;
  logic [AW-1:0] ptr_nxt;
  state_t        start_st;
  logic          unused_adr;

  assign adr_word   = adr[AW+1:2];
  assign in_range   = (adr[31:AW+2] == '0);
  assign burst_req  = (cti == 3'b010) && (bte == 2'b00);
  assign last_cti   = (cti == 3'b111);
  assign ptr_nxt    = ptr_q + AW'(1);
  assign start_st   = burst_req ? S_BURST : S_ACK;
  assign unused_adr = ^adr[1:0];

  // ack_q is only ever set for ACK/BURST, so it doubles as "current beat
  // belongs to a memory access". ptr_q always holds that beat's word.
  assign mem_we = ack_q & cyc & stb & we;

  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sel[i]) begin
          mem[ptr_q][8*i +: 8] <= dat_ms[8*i +: 8];
        end
      end
    end
  end

  // Single-process FSM with registered ack/err/dat_sm. Burst prefetch reads
  // ptr+1 while a write (if any) targets ptr, so there is never a same-word
  // read/write collision and read-after-write sees the new data.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      if (!cyc) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (stb) begin
              if (!in_range) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
              end else if (WAIT > 0) begin
                state_q <= S_WAIT;
                cnt_q   <= WAIT_LD;
              end else begin
                state_q <= start_st;
                ptr_q   <= adr_word;
                ack_q   <= 1'b1;
                dat_q   <= mem[adr_word];
              end
            end
          end
          S_WAIT: begin
            if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end else begin
              state_q <= start_st;
              ptr_q   <= adr_word;
              ack_q   <= 1'b1;
              dat_q   <= mem[adr_word];
            end
          end
          S_ACK: begin
            state_q <= S_IDLE;
          end
          S_BURST: begin
            // Stop on end-of-burst, dropped strobe, or a pointer about to
            // run past the last word; the master's retry then hits IDLE.
            if (!stb || last_cti || (ptr_q == LAST_WORD)) begin
              state_q <= S_IDLE;
            end else begin
              ptr_q <= ptr_nxt;
              ack_q <= 1'b1;
              dat_q <= mem[ptr_nxt];
            end
          end
          S_ERR: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ack    = ack_q;
  assign err    = err_q;
  assign dat_sm = dat_q;
  assign rty    = 1'b0;

endmodule

// File: tb/tb_wshb_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_wshb_mem_slave
// Directed bench for wshb_mem_slave: a WAIT=0 and a WAIT=2 instance share the
// bus signals and are selected by their own cyc. Classic accesses come from a
// vector table; bursts, aborts, boundary crossing and reset are sequences.
// -----------------------------------------------------------------------------
module tb_wshb_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc_a = 1'b0;
  logic        cyc_b = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat_ms = '0;
  logic [3:0]  sel = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] dat_a, dat_b;
  logic        ack_a, ack_b, err_a, err_b, rty_a, rty_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] bv [8];

  always #5 clk = ~clk;

  wshb_mem_slave #(.DEPTH(1024), .WAIT(0)) u_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .cyc(cyc_a), .stb(stb), .we(we),
    .adr(adr), .dat_ms(dat_ms), .sel(sel), .cti(cti), .bte(bte),
    .dat_sm(dat_a), .ack(ack_a), .err(err_a), .rty(rty_a)
  );

  wshb_mem_slave #(.DEPTH(1024), .WAIT(2)) u_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .cyc(cyc_b), .stb(stb), .we(we),
    .adr(adr), .dat_ms(dat_ms), .sel(sel), .cti(cti), .bte(bte),
    .dat_sm(dat_b), .ack(ack_b), .err(err_b), .rty(rty_b)
  );

  typedef struct {
    bit          use_b;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          lat;
    logic        exp_err;
    logic [31:0] exp_d;
    bit          chk_d;
    string       name;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit b, logic w, logic [31:0] a, logic [31:0] d,
                              logic [3:0] s, int lat, logic e,
                              logic [31:0] xd, bit cd, string nm);
    vec_t v;
    v.use_b = b; v.w = w; v.a = a; v.d = d; v.s = s; v.lat = lat;
    v.exp_err = e; v.exp_d = xd; v.chk_d = cd; v.name = nm;
    return v;
  endfunction

  function automatic logic f_ack(bit b);
    return b ? ack_b : ack_a;
  endfunction
  function automatic logic f_err(bit b);
    return b ? err_b : err_a;
  endfunction
  function automatic logic [31:0] f_dat(bit b);
    return b ? dat_b : dat_a;
  endfunction

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_cyc(input bit b, input logic v);
    if (b) cyc_b = v; else cyc_a = v;
  endtask

  task automatic drop_bus();
    cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
  endtask

  task automatic classic(input vec_t v);
    int lat;
    bit hit;
    @(negedge clk);
    set_cyc(v.use_b, 1'b1);
    stb = 1'b1; we = v.w; adr = v.a; dat_ms = v.d; sel = v.s;
    cti = 3'b000; bte = 2'b00;
    lat = 0; hit = 1'b0;
    while (!hit && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      hit = f_ack(v.use_b) | f_err(v.use_b);
    end
    check32({v.name, " latency"}, lat, v.lat);
    check1({v.name, " err"}, f_err(v.use_b), v.exp_err);
    check1({v.name, " ack"}, f_ack(v.use_b), ~v.exp_err);
    if (v.chk_d) check32({v.name, " data"}, f_dat(v.use_b), v.exp_d);
    @(posedge clk); #1;
    check1({v.name, " single pulse"}, f_ack(v.use_b) | f_err(v.use_b), 1'b0);
    drop_bus();
  endtask

  // n beats from a0 using bv[]; abort_after beats accepted -> drop cyc.
  task automatic burst(input bit b, input logic w, input logic [31:0] a0,
                       input int n, input int abort_after, input int exp_lat,
                       input string nm);
    int lat;
    bit hit;
    @(negedge clk);
    set_cyc(b, 1'b1);
    stb = 1'b1; we = w; sel = 4'hF; bte = 2'b00;
    adr = a0; dat_ms = bv[0]; cti = (n == 1) ? 3'b111 : 3'b010;
    lat = 0; hit = 1'b0;
    while (!hit && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      hit = f_ack(b) | f_err(b);
    end
    check32({nm, " first latency"}, lat, exp_lat);
    for (int i = 0; i < n; i++) begin
      check1($sformatf("%s beat%0d ack", nm, i), f_ack(b), 1'b1);
      if (!w) check32($sformatf("%s beat%0d data", nm, i), f_dat(b), bv[i]);
      @(posedge clk); #1;
      if (i + 1 == abort_after) begin
        drop_bus();
        @(posedge clk); #1;
        check1({nm, " ack after abort"}, f_ack(b), 1'b0);
        return;
      end
      if (i + 1 < n) begin
        adr = a0 + 32'(4 * (i + 1));
        dat_ms = bv[i + 1];
        cti = (i + 1 == n - 1) ? 3'b111 : 3'b010;
      end
    end
    check1({nm, " ack after last"}, f_ack(b), 1'b0);
    drop_bus();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit hit;

    vt.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 0, '0, 0, "wr 0x10"));
    vt.push_back(mk(0, 0, 32'h10, '0, 4'hF, 1, 0, 32'hDEADBEEF, 1, "rd 0x10"));
    vt.push_back(mk(0, 1, 32'h20, 32'h00000000, 4'hF, 1, 0, '0, 0, "clr 0x20"));
    vt.push_back(mk(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, 0, '0, 0, "wr sel0101"));
    vt.push_back(mk(0, 0, 32'h20, '0, 4'hF, 1, 0, 32'h00BB00DD, 1, "rd sel0101"));
    vt.push_back(mk(0, 1, 32'h20, 32'h77000000, 4'b1000, 1, 0, '0, 0, "wr sel1000"));
    vt.push_back(mk(0, 0, 32'h22, '0, 4'hF, 1, 0, 32'h77BB00DD, 1, "rd lowbits"));
    vt.push_back(mk(0, 1, 32'h0, 32'h11111111, 4'hF, 1, 0, '0, 0, "wr 0x0"));
    vt.push_back(mk(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1, 1, '0, 1, "wr oob"));
    vt.push_back(mk(0, 0, 32'h0, '0, 4'hF, 1, 0, 32'h11111111, 1, "rd 0x0 kept"));
    vt.push_back(mk(0, 0, 32'h1000, '0, 4'hF, 1, 1, '0, 1, "rd oob"));
    vt.push_back(mk(0, 1, 32'hFFC, 32'h12345678, 4'hF, 1, 0, '0, 0, "wr last"));
    vt.push_back(mk(0, 1, 32'hFF8, 32'h0BAD0FF8, 4'hF, 1, 0, '0, 0, "wr last-1"));
    vt.push_back(mk(0, 0, 32'hFFC, '0, 4'hF, 1, 0, 32'h12345678, 1, "rd last"));
    vt.push_back(mk(0, 0, 32'hFFFFFFFC, '0, 4'hF, 1, 1, '0, 1, "rd top oob"));
    vt.push_back(mk(1, 1, 32'h40, 32'hCAFEF00D, 4'hF, 3, 0, '0, 0, "w2 wr 0x40"));
    vt.push_back(mk(1, 0, 32'h40, '0, 4'hF, 3, 0, 32'hCAFEF00D, 1, "w2 rd 0x40"));
    vt.push_back(mk(1, 0, 32'h1000, '0, 4'hF, 1, 1, '0, 1, "w2 rd oob"));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check1("reset ack_a", ack_a, 1'b0);
    check1("reset err_a", err_a, 1'b0);
    check32("reset dat_a", dat_a, '0);
    check1("reset rty_a", rty_a, 1'b0);
    check1("reset ack_b", ack_b, 1'b0);
    check1("reset rty_b", rty_b, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) classic(vt[i]);

    // Bursts, WAIT=0
    for (int i = 0; i < 4; i++) bv[i] = 32'(i);
    burst(0, 1, 32'h0, 4, 0, 1, "bwr0");
    burst(0, 0, 32'h0, 4, 0, 1, "brd0");

    // Bursts, WAIT=2: only the first beat is delayed
    for (int i = 0; i < 4; i++) bv[i] = 32'hA0 + 32'(i);
    burst(1, 1, 32'h80, 4, 0, 3, "w2 bwr");
    burst(1, 0, 32'h80, 4, 0, 3, "w2 brd");

    // cyc dropped after beat 2 of a 4-beat write
    for (int i = 0; i < 4; i++) bv[i] = 32'h55550000 + 32'(i);
    burst(0, 1, 32'h100, 4, 0, 1, "pre abort");
    for (int i = 0; i < 4; i++) bv[i] = 32'hBB000000 + 32'(i);
    burst(0, 1, 32'h100, 4, 2, 1, "abort wr");
    bv[0] = 32'hBB000000; bv[1] = 32'hBB000001;
    bv[2] = 32'h55550002; bv[3] = 32'h55550003;
    burst(0, 0, 32'h100, 4, 0, 1, "abort rd");

    // Burst that would run past the last word
    @(negedge clk);
    cyc_a = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; bte = 2'b00;
    adr = 32'hFF8; cti = 3'b010;
    @(posedge clk); #1;
    check1("edge beat0 ack", ack_a, 1'b1);
    check32("edge beat0 data", dat_a, 32'h0BAD0FF8);
    @(posedge clk); #1;
    adr = 32'hFFC;
    check1("edge beat1 ack", ack_a, 1'b1);
    check32("edge beat1 data", dat_a, 32'h12345678);
    @(posedge clk); #1;
    adr = 32'h1000;
    check1("edge no ack", ack_a, 1'b0);
    check1("edge no err yet", err_a, 1'b0);
    @(posedge clk); #1;
    check1("edge retry err", err_a, 1'b1);
    check1("edge retry ack", ack_a, 1'b0);
    check32("edge retry data", dat_a, '0);
    drop_bus();

    // Reset pulsed mid-burst on the WAIT=2 instance
    @(negedge clk);
    cyc_b = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; bte = 2'b00;
    adr = 32'h80; cti = 3'b010;
    lat = 0; hit = 1'b0;
    while (!hit && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      hit = ack_b;
    end
    check32("rst pre latency", lat, 3);
    rst_n = 1'b0;
    #1;
    check1("rst ack", ack_b, 1'b0);
    check1("rst err", err_b, 1'b0);
    check32("rst dat", dat_b, '0);
    @(negedge clk);
    rst_n = 1'b1;
    drop_bus();
    classic(mk(1, 0, 32'h84, '0, 4'hF, 3, 0, 32'hA1, 1, "after rst rd"));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
